mips_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with HI/LO result registers for the MIPS pipeline. It accepts one MULT/MULTU/DIV/DIVU operation at a time through a start/busy/done handshake. It computes the result over WIDTH iteration cycles and writes HI/LO. It also supports direct HI/LO moves (MTHI/MTLO). It sits beside the EX stage, and the hazard logic stalls MFHI/MFLO while `busy` is high.

---
 rtl/mips_muldiv_unit_if.sv | 28 ++
 rtl/mips_muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_unit_if.sv
// Handshake/operand bundle for mips_muldiv_unit.
// master: pipeline side (drives start/op/operands/moves); slave: the unit.
interface mips_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO moves.
// Optional feature macro: MULDIV_EARLY_OUT_EN (multiply stops once the
// remaining multiplier magnitude is zero; results are unchanged).
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    mips_muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;     // MUL: product; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] r_mcand;   // multiplicand magnitude, shifted left each step
    logic [WIDTH-1:0]   r_mplier;  // MUL: multiplier magnitude; DIV: divisor magnitude
    logic               r_is_div;
    logic               r_dz;
    logic               r_neg_q;   // product / quotient sign
    logic               r_neg_r;   // remainder sign (dividend sign)
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div_zero;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_mplier_nxt;
    logic               w_last;
    logic               w_mul_last;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_rem_sub;
    logic               w_div_fit;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    // Operand conditioning at accept: signed ops work on magnitudes.
    always_comb begin
        w_a_neg  = bus.op[0] & bus.a[WIDTH-1];
        w_b_neg  = bus.op[0] & bus.b[WIDTH-1];
        w_a_mag  = w_a_neg ? -bus.a : bus.a;
        w_b_mag  = w_b_neg ? -bus.b : bus.b;
        w_b_zero = (bus.b == '0);
    end

    // Per-iteration datapath for shift-add multiply and restoring divide.
    always_comb begin
        w_mplier_nxt = r_mplier >> 1;
        w_last       = (r_cnt == CW'(WIDTH - 1));
        w_mul_last   = w_last || (EARLY_OUT && (w_mplier_nxt == '0));
        w_rem_sh     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_rem_sub    = w_rem_sh - {1'b0, r_mplier};
        w_div_fit    = (w_rem_sh >= {1'b0, r_mplier});
        w_rem_nxt    = w_div_fit ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        w_prod       = r_neg_q ? -r_acc : r_acc;
        w_quo        = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem        = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM, iteration datapath and HI/LO result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_is_div   <= 1'b0;
            r_dz       <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.hi_we) r_hi <= bus.wdata;
                    if (bus.lo_we) r_lo <= bus.wdata;
                    if (bus.start) begin
                        r_div_zero <= 1'b0;
                        r_cnt      <= '0;
                        r_is_div   <= bus.op[1];
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_mplier   <= w_b_mag;
                        r_mcand    <= {{WIDTH{1'b0}}, w_a_mag};
                        if (!bus.op[1]) begin
                            r_acc   <= '0;
                            r_dz    <= 1'b0;
                            r_state <= S_MUL;
                        end else if (w_b_zero) begin
                            // Raw dividend parked in the remainder half for HI.
                            r_acc   <= {bus.a, {WIDTH{1'b0}}};
                            r_dz    <= 1'b1;
                            r_state <= S_FIX;
                        end else begin
                            r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                            r_dz    <= 1'b0;
                            r_state <= S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_nxt;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_mul_last) r_state <= S_FIX;
                end
                S_DIV: begin
                    r_acc <= {w_rem_nxt, r_acc[WIDTH-2:0], w_div_fit};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_dz) begin
                        r_hi       <= r_acc[2*WIDTH-1:WIDTH];
                        r_lo       <= '1;
                        r_div_zero <= 1'b1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit (WIDTH=32): a cycle-level
// reference model built from plain arithmetic and a busy countdown, compared
// every cycle, plus directed literal expectations for the key vectors.
module tb_mips_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    bit   cmp_en;

    mips_muldiv_unit_if #(.WIDTH(W)) bus ();

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, got, exp);
        end
    endtask

    function automatic int bitlen(input logic [W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
        return (n == 0) ? 1 : n;
    endfunction

    // Architectural result and latency of one operation.
    task automatic model_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] hi, output logic [W-1:0] lo,
                            output logic dz, output int lat);
        logic [63:0] up;
        longint      sp, sa, sb, q, r;
        logic [W-1:0] bmag;
        dz = 1'b0;
        case (op)
            2'b00: begin
                up = {32'd0, a} * {32'd0, b};
                hi = up[63:32]; lo = up[31:0];
                lat = EARLY ? bitlen(b) + 2 : W + 2;
            end
            2'b01: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = sp;
                hi = up[63:32]; lo = up[31:0];
                bmag = b[W-1] ? (32'd0 - b) : b;
                lat = EARLY ? bitlen(bmag) + 2 : W + 2;
            end
            default: begin
                if (b == '0) begin
                    hi = a; lo = '1; dz = 1'b1; lat = 2;
                end else begin
                    if (op == 2'b10) begin
                        sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
                    end else begin
                        sa = longint'($signed(a)); sb = longint'($signed(b));
                    end
                    q = sa / sb; r = sa % sb;
                    up = q; lo = up[31:0];
                    up = r; hi = up[31:0];
                    lat = W + 2;
                end
            end
        endcase
    endtask

    // Reference model state: m_left = cycles still busy (done when it is 1).
    int           m_left;
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    logic         m_dz, p_dz;

    always @(posedge clk or negedge rst_n) begin
        int lat;
        if (!rst_n) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_dz = 1'b0;
        end else if (m_left > 0) begin
            if (m_left == 2) begin
                m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
            end
            m_left--;
        end else begin
            if (bus.hi_we) m_hi = bus.wdata;
            if (bus.lo_we) m_lo = bus.wdata;
            if (bus.start) begin
                model_op(bus.op, bus.a, bus.b, p_hi, p_lo, p_dz, lat);
                m_left = lat;
                m_dz   = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy",     {31'd0, bus.busy},     {31'd0, (m_left > 0)});
            check("done",     {31'd0, bus.done},     {31'd0, (m_left == 1)});
            check("hi",       bus.hi,                m_hi);
            check("lo",       bus.lo,                m_lo);
            check("div_zero", {31'd0, bus.div_zero}, {31'd0, m_dz});
        end
    end

    // One operation; mode 1 pokes hi_we and a second start while busy.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input logic edz, input int elat, input int mode);
        int k;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        k = 1;
        while (!bus.done && k < 100) begin
            if (mode == 1 && k == 3) begin
                bus.hi_we = 1'b1; bus.wdata = 32'h1234;
                bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd9; bus.b = 32'd9;
            end else begin
                bus.hi_we = 1'b0; bus.start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.hi_we = 1'b0; bus.start = 1'b0;
        check({name, ".latency"}, k, elat);
        check({name, ".hi"}, bus.hi, ehi);
        check({name, ".lo"}, bus.lo, elo);
        check({name, ".div_zero"}, {31'd0, bus.div_zero}, {31'd0, edz});
        @(negedge clk);
        check({name, ".busy_after"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cmp_en = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        check("rst.busy", {31'd0, bus.busy}, 32'd0);
        check("rst.hi", bus.hi, 32'd0);
        check("rst.lo", bus.lo, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0,
               EARLY ? 34 : 34, 0);
        run_op("mult_m3x7", 2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0,
               EARLY ? 5 : 34, 0);
        run_op("div_m7d2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 0);
        run_op("div_7dm2", 2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 34, 0);
        run_op("div_min", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 34, 0);
        run_op("divu_0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 2, 0);
        run_op("multu_clr", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, EARLY ? 4 : 34, 0);
        run_op("divu_big", 2'b10, 32'hFFFFFFFF, 32'd16, 32'd15, 32'h0FFFFFFF, 1'b0, 34, 0);
        run_op("mult_negneg", 2'b01, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd0, 32'd6, 1'b0,
               EARLY ? 4 : 34, 0);
        run_op("mult_b0", 2'b01, 32'h12345678, 32'd0, 32'd0, 32'd0, 1'b0, EARLY ? 3 : 34, 0);
        run_op("div_0_signed", 2'b11, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 2, 0);
        run_op("busy_move", 2'b00, 32'h10, 32'h10, 32'd0, 32'h100, 1'b0, EARLY ? 7 : 34, 1);

        // Moves in IDLE are visible the following cycle.
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h1234;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("mthi", bus.hi, 32'h1234);
        check("mtlo", bus.lo, 32'h1234);

        // Reset mid-operation aborts without a done pulse.
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort.busy", {31'd0, bus.busy}, 32'd0);
        check("abort.done", {31'd0, bus.done}, 32'd0);
        check("abort.hi", bus.hi, 32'd0);
        check("abort.lo", bus.lo, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_rst", 2'b00, 32'd1000, 32'd1000, 32'd0, 32'd1000000, 1'b0,
               EARLY ? 12 : 34, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
